// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with a writable control store,
// opcode dispatch map and a small call/return stack. One registered control
// word is issued per non-stalled cycle; the next micro-address is computed
// from the SEQ/CSEL/NA fields of the word currently on cwrd.
//
// Fetch-phase state (exposed internally as `state` for checkers):
//   ST_IDLE - nothing fetched since reset; cw_valid=0, next fetch is RESET_ADDR
//   ST_RUN  - cwrd holds a word fetched from a valid address
//   ST_BAD  - last fetch was out of range; cwrd=0, next fetch is RESET_ADDR
module micro_sequencer #(
  parameter int CW_W       = 29,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 25,
  parameter int CS_W       = 2,
  parameter int OPC_W      = 4,
  parameter int STK_D      = 2,
  parameter int RESET_ADDR = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [2**CS_W-1:0]   cond,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 ld_we,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [CW_W-1:0]      ld_data,
  input  logic                 map_we,
  input  logic [OPC_W-1:0]     map_opc,
  input  logic [ADDR_W-1:0]    map_addr,
  output logic [CW_W-1:0]      cwrd,
  output logic [ADDR_W-1:0]    upc,
  output logic                 cw_valid,
  output logic                 err
);

  localparam int SP_W = $clog2(STK_D + 1);

  localparam logic [ADDR_W-1:0] RESET_ADDR_L = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_L      = (ADDR_W + 1)'(DEPTH);
  localparam logic [SP_W-1:0]   STK_FULL     = SP_W'(STK_D);

  localparam logic [2:0] SEQ_NEXT     = 3'b000;
  localparam logic [2:0] SEQ_JUMP     = 3'b001;
  localparam logic [2:0] SEQ_CBR      = 3'b010;
  localparam logic [2:0] SEQ_DISPATCH = 3'b011;
  localparam logic [2:0] SEQ_CALL     = 3'b100;
  localparam logic [2:0] SEQ_RET      = 3'b101;
  localparam logic [2:0] SEQ_WAIT     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BAD  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Storage: control store and dispatch map are not reset (retained through
  // reset). The stack array is sized to the pointer range so any pointer
  // value indexes safely; only entries 0..STK_D-1 are ever written.
  logic [CW_W-1:0]   mem  [DEPTH];
  logic [ADDR_W-1:0] dmap [2**OPC_W];
  logic [ADDR_W-1:0] stk  [2**SP_W];
  logic [SP_W-1:0]   sp;

  // Decoded fields of the word currently presented on cwrd.
  logic [ADDR_W-1:0] na;
  logic [2:0]        seq;
  logic [CS_W-1:0]   csel;
  logic              c;
  logic [ADDR_W-1:0] inc;
  logic [SP_W-1:0]   top_idx;

  // Next-address outputs of the sequencing logic.
  logic [ADDR_W-1:0] nxt;
  logic              push;
  logic              pop;
  logic              stk_err;
  logic              in_range;

  assign na       = cwrd[ADDR_W-1:0];
  assign seq      = cwrd[ADDR_W+2:ADDR_W];
  assign csel     = cwrd[ADDR_W+2+CS_W:ADDR_W+3];
  assign c        = cond[csel];
  assign inc      = upc + ADDR_W'(1);
  assign top_idx  = sp - SP_W'(1);
  assign cw_valid = (state != ST_IDLE);

  // Fetch-phase state register; frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (!stall) begin
      state <= state_nxt;
    end
  end

  // Next-address generation, stack control and next fetch phase.
  always_comb begin
    nxt     = RESET_ADDR_L;
    push    = 1'b0;
    pop     = 1'b0;
    stk_err = 1'b0;
    if (state == ST_RUN) begin
      case (seq)
        SEQ_NEXT:     nxt = inc;
        SEQ_JUMP:     nxt = na;
        SEQ_CBR:      nxt = c ? na : inc;
        SEQ_DISPATCH: nxt = dmap[opcode];
        SEQ_CALL: begin
          // A full stack drops the return address but still takes the jump.
          nxt = na;
          if (sp == STK_FULL) stk_err = 1'b1;
          else                push    = 1'b1;
        end
        SEQ_RET: begin
          // Returning with nothing on the stack restarts the microprogram.
          if (sp == '0) begin
            stk_err = 1'b1;
          end else begin
            pop = 1'b1;
            nxt = stk[top_idx];
          end
        end
        SEQ_WAIT:     nxt = c ? na : upc;
        default:      nxt = RESET_ADDR_L;
      endcase
    end
    in_range  = ({1'b0, nxt} < DEPTH_L);
    state_nxt = in_range ? ST_RUN : ST_BAD;
  end

  // Fetch registers, call stack and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwrd <= '0;
      upc  <= '0;
      err  <= 1'b0;
      sp   <= '0;
      for (int i = 0; i < 2**SP_W; i++) begin
        stk[i] <= '0;
      end
    end else if (!stall) begin
      upc  <= nxt;
      // mem is read here with the pre-edge contents, so a same-edge write
      // to the fetched address is seen only on the following fetch.
      cwrd <= in_range ? mem[nxt] : '0;
      if (!in_range || stk_err) begin
        err <= 1'b1;
      end
      if (push) begin
        stk[sp] <= inc;
        sp      <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= top_idx;
      end
    end
  end

  // Run-time loading of the control store and dispatch map; independent of
  // stall and reset. Out-of-range store writes are silently dropped.
  always_ff @(posedge clk) begin
    if (ld_we && ({1'b0, ld_addr} < DEPTH_L)) begin
      mem[ld_addr] <= ld_data;
    end
    if (map_we) begin
      dmap[map_opc] <= map_addr;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: reset checks, hand-written
// multi-cycle sequences, a table of single-step sequencing vectors and a
// randomized run compared against a behavioural model.
module tb_micro_sequencer;

  localparam int CW_W  = 29;
  localparam int DEPTH = 25;
  localparam int RA    = 8;
  localparam int STK_D = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        ld_we;
  logic [4:0]  ld_addr;
  logic [28:0] ld_data;
  logic        map_we;
  logic [3:0]  map_opc;
  logic [4:0]  map_addr;
  logic [28:0] cwrd;
  logic [4:0]  upc;
  logic        cw_valid;
  logic        err;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .cond     (cond),
    .opcode   (opcode),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .map_we   (map_we),
    .map_opc  (map_opc),
    .map_addr (map_addr),
    .cwrd     (cwrd),
    .upc      (upc),
    .cw_valid (cw_valid),
    .err      (err)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [28:0] m_mem [DEPTH];
  logic [4:0]  m_map [16];
  int          m_upc;
  logic [28:0] m_cw;
  logic        m_valid;
  logic        m_err;
  int          stk_q[$];

  function automatic logic [28:0] mk(input logic [2:0] s, input logic [1:0] cs,
                                     input logic [4:0] na, input logic [18:0] hi);
    return {hi, cs, s, na};
  endfunction

  task automatic model_reset();
    m_upc = 0; m_cw = '0; m_valid = 1'b0; m_err = 1'b0;
    stk_q.delete();
  endtask

  // One clock edge worth of behaviour, using the inputs currently driven.
  task automatic model_step();
    int n;
    int inc;
    logic [2:0] s;
    logic [1:0] cs;
    int na;
    logic cv;
    if (!stall) begin
      if (!m_valid || m_upc >= DEPTH) begin
        n = RA;
      end else begin
        s   = m_cw[7:5];
        cs  = m_cw[9:8];
        na  = int'(m_cw[4:0]);
        cv  = cond[cs];
        inc = (m_upc + 1) % 32;
        case (s)
          3'd0: n = inc;
          3'd1: n = na;
          3'd2: n = cv ? na : inc;
          3'd3: n = int'(m_map[opcode]);
          3'd4: begin
            if (stk_q.size() < STK_D) stk_q.push_back(inc);
            else m_err = 1'b1;
            n = na;
          end
          3'd5: begin
            if (stk_q.size() == 0) begin n = RA; m_err = 1'b1; end
            else n = stk_q.pop_back();
          end
          3'd6: n = cv ? na : m_upc;
          default: n = RA;
        endcase
      end
      m_upc   = n;
      m_valid = 1'b1;
      if (n < DEPTH) m_cw = m_mem[n];
      else begin m_cw = '0; m_err = 1'b1; end
    end
    if (ld_we && int'(ld_addr) < DEPTH) m_mem[ld_addr] = ld_data;
    if (map_we) m_map[map_opc] = map_addr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [28:0] d);
    ld_we = 1'b1; ld_addr = 5'(a); ld_data = d;
    tick();
    ld_we = 1'b0;
    if (a < DEPTH) m_mem[a] = d;
  endtask

  task automatic load_map(input int o, input int a);
    map_we = 1'b1; map_opc = 4'(o); map_addr = 5'(a);
    tick();
    map_we = 1'b0;
    m_map[o] = 5'(a);
  endtask

  task automatic chk_state(input string tag, input int eu, input logic [28:0] ec, input logic ee);
    chk({tag, "_upc"},  32'(upc),  32'(eu));
    chk({tag, "_cwrd"}, 32'(cwrd), 32'(ec));
    chk({tag, "_err"},  32'(err),  32'(ee));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] seq;
    logic [1:0] csel;
    logic [4:0] na;
    logic [3:0] cnd;
    logic [3:0] opc;
    logic [4:0] exp_upc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];

  logic [28:0] w;
  logic [28:0] w_old;
  logic [28:0] e_cw;

  initial begin
    vecs[0]  = '{3'd0, 2'd0, 5'd0,  4'h0, 4'd0, 5'd4,  1'b0}; // NEXT
    vecs[1]  = '{3'd1, 2'd0, 5'd12, 4'h0, 4'd0, 5'd12, 1'b0}; // JUMP
    vecs[2]  = '{3'd2, 2'd2, 5'd12, 4'h4, 4'd0, 5'd12, 1'b0}; // CBR taken
    vecs[3]  = '{3'd2, 2'd2, 5'd12, 4'h0, 4'd0, 5'd4,  1'b0}; // CBR not taken
    vecs[4]  = '{3'd2, 2'd0, 5'd20, 4'h1, 4'd0, 5'd20, 1'b0}; // CBR cond[0]
    vecs[5]  = '{3'd3, 2'd0, 5'd0,  4'h0, 4'd5, 5'd17, 1'b0}; // DISPATCH 5
    vecs[6]  = '{3'd3, 2'd0, 5'd0,  4'h0, 4'd2, 5'd11, 1'b0}; // DISPATCH 2
    vecs[7]  = '{3'd4, 2'd0, 5'd20, 4'h0, 4'd0, 5'd20, 1'b0}; // CALL
    vecs[8]  = '{3'd5, 2'd0, 5'd0,  4'h0, 4'd0, 5'd8,  1'b1}; // RET empty
    vecs[9]  = '{3'd6, 2'd1, 5'd15, 4'hd, 4'd0, 5'd3,  1'b0}; // WAIT hold
    vecs[10] = '{3'd6, 2'd1, 5'd15, 4'h2, 4'd0, 5'd15, 1'b0}; // WAIT go
    vecs[11] = '{3'd7, 2'd0, 5'd0,  4'h0, 4'd0, 5'd8,  1'b0}; // RESTART
    vecs[12] = '{3'd1, 2'd0, 5'd30, 4'h0, 4'd0, 5'd30, 1'b1}; // JUMP OOR
    vecs[13] = '{3'd1, 2'd0, 5'd24, 4'h0, 4'd0, 5'd24, 1'b0}; // last valid
    vecs[14] = '{3'd1, 2'd0, 5'd25, 4'h0, 4'd0, 5'd25, 1'b1}; // first invalid

    stall = 1'b0; cond = '0; opcode = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    map_we = 1'b0; map_opc = '0; map_addr = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    // Reset state
    chk("rst_upc",   32'(upc),      32'd0);
    chk("rst_cwrd",  32'(cwrd),     32'd0);
    chk("rst_valid", 32'(cw_valid), 32'd0);
    chk("rst_err",   32'(err),      32'd0);

    // Fill store and map while held in reset.
    for (int i = 0; i < DEPTH; i++) load_word(i, mk(3'd0, 2'd0, 5'd0, 19'(i + 1)));
    for (int i = 0; i < 16; i++) m_map[i] = '0;
    load_map(5, 17);
    load_map(2, 11);

    // Reset and fetch.
    load_word(8, 29'h0000_0020);
    load_word(0, 29'h0);
    chk("inrst_valid", 32'(cw_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk("e1_upc",   32'(upc),      32'd8);
    chk("e1_valid", 32'(cw_valid), 32'd1);
    chk("e1_cwrd",  32'(cwrd),     32'h20);
    tick();
    chk_state("e2", 0, 29'h0, 1'b0);
    tick();
    chk_state("e3", 1, m_mem[1], 1'b0);

    // Stall for three cycles with a simultaneous load of the next word.
    stall = 1'b1;
    w = mk(3'd1, 2'd0, 5'd5, 19'h5a5a5);
    ld_we = 1'b1; ld_addr = 5'd2; ld_data = w;
    tick();
    ld_we = 1'b0; m_mem[2] = w;
    chk_state("stall0", 1, m_mem[1], 1'b0);
    chk("stall0_valid", 32'(cw_valid), 32'd1);
    tick();
    chk_state("stall1", 1, m_mem[1], 1'b0);
    tick();
    chk_state("stall2", 1, m_mem[1], 1'b0);
    stall = 1'b0;
    tick();
    chk_state("unstall", 2, w, 1'b0);
    tick();
    chk_state("after_ld", 5, m_mem[5], 1'b0);

    // Table of single-step vectors: 8 -> 3 -> vector word at 3 -> target.
    reset = 1'b0; #1;
    load_word(8, mk(3'd1, 2'd0, 5'd3, 19'h00808));
    for (int v = 0; v < 15; v++) begin
      reset = 1'b0; #1;
      w = mk(vecs[v].seq, vecs[v].csel, vecs[v].na, 19'(v * 977 + 3));
      load_word(3, w);
      cond = vecs[v].cnd; opcode = vecs[v].opc;
      reset = 1'b1;
      tick();
      tick();
      chk($sformatf("v%0d_at3", v), 32'(upc), 32'd3);
      tick();
      e_cw = (int'(vecs[v].exp_upc) < DEPTH) ? m_mem[vecs[v].exp_upc] : 29'h0;
      chk_state($sformatf("v%0d", v), int'(vecs[v].exp_upc), e_cw, vecs[v].exp_err);
    end

    // Out-of-range jump, then forced return to RESET_ADDR.
    reset = 1'b0; #1;
    load_word(3, mk(3'd1, 2'd0, 5'd30, 19'h1));
    cond = '0;
    reset = 1'b1;
    tick(); tick(); tick();
    chk_state("oor", 30, 29'h0, 1'b1);
    chk("oor_valid", 32'(cw_valid), 32'd1);
    tick();
    chk_state("oor_next", 8, m_mem[8], 1'b1);

    // Dispatch, subroutine call/return and stack overflow.
    reset = 1'b0; #1;
    load_word(8,  mk(3'd3, 2'd0, 5'd0,  19'h11));
    load_word(17, mk(3'd4, 2'd0, 5'd20, 19'h12));
    load_word(20, mk(3'd5, 2'd0, 5'd0,  19'h13));
    load_word(18, mk(3'd4, 2'd0, 5'd21, 19'h14));
    load_word(21, mk(3'd4, 2'd0, 5'd22, 19'h15));
    load_word(22, mk(3'd4, 2'd0, 5'd23, 19'h16));
    load_word(23, mk(3'd5, 2'd0, 5'd0,  19'h17));
    opcode = 4'd5;
    reset = 1'b1;
    tick(); chk("sub_8",  32'(upc), 32'd8);
    tick(); chk_state("sub_disp", 17, m_mem[17], 1'b0);
    tick(); chk_state("sub_call", 20, m_mem[20], 1'b0);
    tick(); chk_state("sub_ret",  18, m_mem[18], 1'b0);
    tick(); chk_state("sub_c1",   21, m_mem[21], 1'b0);
    tick(); chk_state("sub_c2",   22, m_mem[22], 1'b0);
    tick(); chk_state("sub_c3",   23, m_mem[23], 1'b1);
    tick(); chk_state("sub_ret2", 22, m_mem[22], 1'b1);

    // WAIT with a same-edge store write (read-first).
    reset = 1'b0; #1;
    load_word(8, mk(3'd1, 2'd0, 5'd3, 19'h21));
    w_old = mk(3'd6, 2'd1, 5'd15, 19'h22);
    load_word(3, w_old);
    cond = 4'h0;
    reset = 1'b1;
    tick(); tick(); tick();
    chk_state("wait_hold", 3, w_old, 1'b0);
    w = mk(3'd1, 2'd0, 5'd12, 19'h23);
    ld_we = 1'b1; ld_addr = 5'd3; ld_data = w;
    tick();
    ld_we = 1'b0; m_mem[3] = w;
    chk_state("wait_rdfirst", 3, w_old, 1'b0);
    tick();
    chk_state("wait_newword", 3, w, 1'b0);
    tick();
    chk_state("wait_exit", 12, m_mem[12], 1'b0);
    tick();
    chk("run_13", 32'(upc), 32'd13);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_upc",   32'(upc),      32'd0);
    chk("arst_cwrd",  32'(cwrd),     32'd0);
    chk("arst_valid", 32'(cw_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk_state("arst_rel", 8, m_mem[8], 1'b0);
    tick();
    chk_state("arst_store3", 3, w, 1'b0);
    tick();
    chk_state("arst_store12", 12, m_mem[12], 1'b0);

    // Randomized run against the model.
    reset = 1'b0; #1;
    for (int i = 0; i < DEPTH; i++)
      load_word(i, mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)), 19'($urandom())));
    for (int i = 0; i < 16; i++) load_map(i, $urandom_range(0, 31));
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        reset = 1'b0; #1;
        model_reset();
        reset = 1'b1;
      end
      stall    = ($urandom_range(0, 3) == 0);
      cond     = 4'($urandom_range(0, 15));
      opcode   = 4'($urandom_range(0, 15));
      ld_we    = ($urandom_range(0, 7) == 0);
      ld_addr  = 5'($urandom_range(0, 31));
      ld_data  = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), 19'($urandom()));
      map_we   = ($urandom_range(0, 15) == 0);
      map_opc  = 4'($urandom_range(0, 15));
      map_addr = 5'($urandom_range(0, 31));
      model_step();
      tick();
      chk("rnd_upc",   32'(upc),      32'(m_upc));
      chk("rnd_cwrd",  32'(cwrd),     32'(m_cw));
      chk("rnd_valid", 32'(cw_valid), 32'(m_valid));
      chk("rnd_err",   32'(err),      32'(m_err));
    end
    stall = 1'b0; ld_we = 1'b0; map_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
